// File: rtl/tower_stack_engine.sv
// tower_stack_engine
//
// Gameplay engine for the stacking game. The active block slides left/right
// one pixel per motion tick and bounces off both walls. A drop pulse places
// it, and it is trimmed to the overlap with the block below. A miss costs a
// chance. The engine tracks row, score, remaining chances and game status,
// and drives the VGA renderer and HUD.
//
// Optional feature macro: SPEED_RAMP_EN
//   defined   : step period = max(TICK_DIV - score*TICK_STEP, TICK_MIN), sampled at spawn
//   undefined : step period fixed at TICK_DIV (TICK_STEP/TICK_MIN unused)
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   start        in   one-cycle pulse: begin/restart game (honoured in idle/won/lost)
//   drop         in   one-cycle pulse: place block (honoured while moving)
//   x            out  left edge of moving block
//   prev_x       out  left edge of last placed block
//   width        out  current block width
//   y            out  top y of moving block
//   sync         out  one-cycle pulse per motion step
//   bypass_erase out  one-cycle pulse on row commit
//   overlap      out  last placement overlapped
//   score        out  rows placed, saturates at 15
//   chances      out  remaining misses
//   game_status  out  00 idle, 01 playing, 10 won, 11 lost
module tower_stack_engine #(
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned BLOCK_W   = 40,
    parameter int unsigned ROW_H     = 4,
    parameter int unsigned Y_BASE    = 116,
    parameter int unsigned ROWS      = 15,
    parameter int unsigned CHANCES   = 3,
    parameter int unsigned TICK_DIV  = 833333,
    parameter int unsigned TICK_STEP = 50000,
    parameter int unsigned TICK_MIN  = 200000
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           drop,
    output logic [X_W-1:0] x,
    output logic [X_W-1:0] prev_x,
    output logic [X_W-1:0] width,
    output logic [Y_W-1:0] y,
    output logic           sync,
    output logic           bypass_erase,
    output logic           overlap,
    output logic [3:0]     score,
    output logic [3:0]     chances,
    output logic [1:0]     game_status
);

    typedef enum logic [2:0] {
        StIdle,
        StSpawn,
        StMove,
        StPlace,
        StCheck,
        StWin,
        StLose
    } state_e;

    localparam logic [X_W-1:0] XOne      = X_W'(1);
    localparam logic [X_W-1:0] ScreenW   = X_W'(SCREEN_W);
    localparam logic [X_W-1:0] PrevXRst  = X_W'((SCREEN_W - BLOCK_W) / 2);
    localparam logic [X_W-1:0] WidthRst  = X_W'(BLOCK_W);
    localparam logic [Y_W-1:0] YRst      = Y_W'(Y_BASE - ROW_H);
    localparam logic [Y_W-1:0] RowH      = Y_W'(ROW_H);
    localparam logic [3:0]     ChanceRst = 4'(CHANCES);
    localparam logic [3:0]     RowsWin   = 4'(ROWS);

    state_e         state_q, state_d;
    logic           dir_q, dir_d;          // 1: moving right
    logic [X_W-1:0] x_q, x_d;
    logic [X_W-1:0] prev_x_q, prev_x_d;
    logic [X_W-1:0] width_q, width_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [3:0]     score_q, score_d;
    logic [3:0]     chances_q, chances_d;
    logic           overlap_q, overlap_d;
    logic           sync_q, sync_d;
    logic           bypass_q, bypass_d;
    logic [X_W:0]   lo_q, lo_d;
    logic [X_W:0]   hi_q, hi_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           restart_q, restart_d;  // restart requested from won/lost
    logic [31:0]    period;

    //------------------------------------------------------------------
    // Step period
    //------------------------------------------------------------------
`ifdef SPEED_RAMP_EN
    logic signed [63:0] ramp_raw;
    logic [31:0]        ramp_period;
    logic [31:0]        period_q, period_d;

    always_comb begin
        ramp_raw = $signed(64'(TICK_DIV)) - $signed(64'(score_q)) * $signed(64'(TICK_STEP));
        ramp_period = (ramp_raw < $signed(64'(TICK_MIN))) ? 32'(TICK_MIN) : ramp_raw[31:0];
    end

    always_comb begin
        period_d = period_q;
        if (state_q == StIdle) begin
            period_d = 32'(TICK_DIV);
        end else if (state_q == StSpawn) begin
            period_d = ramp_period;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_q <= 32'(TICK_DIV);
        end else begin
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{32'(TICK_STEP), 32'(TICK_MIN)};
    assign period = 32'(TICK_DIV);
`endif

    logic tick;
    assign tick = (cnt_q == period - 32'd1);

    //------------------------------------------------------------------
    // Motion step with wall bounce
    //------------------------------------------------------------------
    logic [X_W-1:0] x_max;
    logic [X_W-1:0] step_x;
    logic           step_dir;

    always_comb begin
        x_max    = ScreenW - width_q;
        step_x   = x_q;
        step_dir = dir_q;
        // A full-width block has nowhere to go.
        if (x_max != '0) begin
            if (x_q == '0) begin
                step_dir = 1'b1;
                step_x   = x_q + XOne;
            end else if (x_q >= x_max) begin
                step_dir = 1'b0;
                step_x   = x_q - XOne;
            end else if (dir_q) begin
                step_x = x_q + XOne;
            end else begin
                step_x = x_q - XOne;
            end
        end
    end

    //------------------------------------------------------------------
    // Overlap window, one bit wider than the x bus so x+width cannot wrap.
    // The placed block below always has the current width: width only
    // changes on a successful placement, which also makes it the new base.
    //------------------------------------------------------------------
    logic [X_W:0] x_lo, x_hi, p_lo, p_hi, win_lo, win_hi;

    always_comb begin
        x_lo   = {1'b0, x_q};
        x_hi   = x_lo + {1'b0, width_q};
        p_lo   = {1'b0, prev_x_q};
        p_hi   = p_lo + {1'b0, width_q};
        win_lo = (x_lo > p_lo) ? x_lo : p_lo;
        win_hi = (x_hi < p_hi) ? x_hi : p_hi;
    end

    logic [3:0] score_inc;
    assign score_inc = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    logic reinit;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        x_d       = x_q;
        prev_x_d  = prev_x_q;
        width_d   = width_q;
        y_d       = y_q;
        score_d   = score_q;
        chances_d = chances_q;
        overlap_d = overlap_q;
        sync_d    = 1'b0;
        bypass_d  = 1'b0;
        lo_d      = lo_q;
        hi_d      = hi_q;
        cnt_d     = '0;
        restart_d = restart_q;
        reinit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                reinit = 1'b1;
                if (start || restart_q) begin
                    state_d   = StSpawn;
                    restart_d = 1'b0;
                end
            end
            StSpawn: begin
                x_d     = '0;
                dir_d   = 1'b1;
                state_d = StMove;
            end
            StMove: begin
                // Drop has priority over a coincident tick.
                if (drop) begin
                    state_d = StPlace;
                end else if (tick) begin
                    sync_d = 1'b1;
                    x_d    = step_x;
                    dir_d  = step_dir;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StPlace: begin
                lo_d      = win_lo;
                hi_d      = win_hi;
                overlap_d = (win_hi > win_lo);
                state_d   = StCheck;
            end
            StCheck: begin
                if (overlap_q) begin
                    width_d  = X_W'(hi_q - lo_q);
                    prev_x_d = lo_q[X_W-1:0];
                    x_d      = lo_q[X_W-1:0];
                    y_d      = y_q - RowH;
                    score_d  = score_inc;
                    bypass_d = 1'b1;
                    state_d  = (score_inc == RowsWin) ? StWin : StSpawn;
                end else begin
                    chances_d = chances_q - 4'd1;
                    state_d   = (chances_q == 4'd1) ? StLose : StSpawn;
                end
            end
            StWin, StLose: begin
                if (start) begin
                    reinit    = 1'b1;
                    restart_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reinit) begin
            dir_d     = 1'b1;
            x_d       = '0;
            prev_x_d  = PrevXRst;
            width_d   = WidthRst;
            y_d       = YRst;
            score_d   = '0;
            chances_d = ChanceRst;
            overlap_d = 1'b0;
            lo_d      = '0;
            hi_d      = '0;
        end
    end

    //------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            dir_q     <= 1'b1;
            x_q       <= '0;
            prev_x_q  <= PrevXRst;
            width_q   <= WidthRst;
            y_q       <= YRst;
            score_q   <= '0;
            chances_q <= ChanceRst;
            overlap_q <= 1'b0;
            sync_q    <= 1'b0;
            bypass_q  <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            cnt_q     <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            x_q       <= x_d;
            prev_x_q  <= prev_x_d;
            width_q   <= width_d;
            y_q       <= y_d;
            score_q   <= score_d;
            chances_q <= chances_d;
            overlap_q <= overlap_d;
            sync_q    <= sync_d;
            bypass_q  <= bypass_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    always_comb begin
        unique case (state_q)
            StIdle:  game_status = 2'b00;
            StWin:   game_status = 2'b10;
            StLose:  game_status = 2'b11;
            default: game_status = 2'b01;
        endcase
    end

    assign x            = x_q;
    assign prev_x       = prev_x_q;
    assign width        = width_q;
    assign y            = y_q;
    assign sync         = sync_q;
    assign bypass_erase = bypass_q;
    assign overlap      = overlap_q;
    assign score        = score_q;
    assign chances      = chances_q;

endmodule
